// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolution controller: funct3 conditions,
// request types and the controller FSM state type.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] RT_BRANCH = 2'b00;
  localparam logic [1:0] RT_JAL    = 2'b01;
  localparam logic [1:0] RT_JALR   = 2'b10;
  localparam logic [1:0] RT_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RESOLVE  = 2'd1,
    S_REDIRECT = 2'd2,
    S_FLUSH    = 2'd3
  } branch_state_t;

endpackage

// File: rtl/branch_cond_unit.sv
// Combinational branch condition evaluator covering all six RV32 conditions;
// funct3 010/011 are flagged illegal and never taken.
module branch_cond_unit
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [2:0]      funct3_i,
  output logic            taken_o,
  output logic            illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = (rs1_i == rs2_i);
      F3_BNE:  taken_o = (rs1_i != rs2_i);
      F3_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
      F3_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
      F3_BLTU: taken_o = (rs1_i <  rs2_i);
      F3_BGEU: taken_o = (rs1_i >= rs2_i);
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump resolution and fetch-redirect controller with fixed-length flush.
// Define BRANCH_PERF_EN to build the retired/taken performance counters.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_type,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_imm,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            flush,
  output logic            done,
  output logic            illegal,
  output logic            misalign,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_taken,
  output branch_state_t   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; redirect_valid/redirect_pc never change while waiting for ready.

  branch_state_t   state_q, state_d;
  logic [1:0]      type_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] rs1_q, rs2_q, pc_q, imm_q;
  logic [XLEN-1:0] target_q, target_d;
  logic [3:0]      cnt_q, cnt_d;

  logic            cond_taken, cond_illegal;
  logic            res_illegal, res_taken, res_misalign;
  logic [XLEN-1:0] res_target;

  branch_cond_unit #(.XLEN(XLEN)) u_cond (
    .rs1_i     (rs1_q),
    .rs2_i     (rs2_q),
    .funct3_i  (f3_q),
    .taken_o   (cond_taken),
    .illegal_o (cond_illegal)
  );

  always_comb begin
    res_illegal  = (type_q == RT_RSVD) || ((type_q == RT_BRANCH) && cond_illegal);
    res_taken    = !res_illegal && ((type_q == RT_BRANCH) ? cond_taken : 1'b1);
    res_target   = (type_q == RT_JALR) ? ((rs1_q + imm_q) & {{(XLEN-1){1'b1}}, 1'b0})
                                       : (pc_q + imm_q);
    res_misalign = res_taken && (res_target[1:0] != 2'b00);
  end

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    cnt_d          = cnt_q;
    req_ready      = 1'b0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    done           = 1'b0;
    illegal        = 1'b0;
    misalign       = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        state_d = S_IDLE;
        if (res_illegal)       illegal  = 1'b1;
        else if (!res_taken)   done     = 1'b1;
        else if (res_misalign) misalign = 1'b1;
        else begin
          target_d = res_target;
          state_d  = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready) begin
          cnt_d   = 4'(FLUSH_CYCLES);
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      cnt_q    <= '0;
      type_q   <= '0;
      f3_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      if (state_q == S_IDLE && req_valid) begin
        type_q <= req_type;
        f3_q   <= req_funct3;
        rs1_q  <= req_rs1;
        rs2_q  <= req_rs2;
        pc_q   <= req_pc;
        imm_q  <= req_imm;
      end
    end
  end

  assign redirect_pc = target_q;
  assign dbg_state   = state_q;

`ifdef BRANCH_PERF_EN
  logic [31:0] perf_br_q, perf_tk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_q <= '0;
      perf_tk_q <= '0;
    end else begin
      if (done || illegal || misalign)     perf_br_q <= perf_br_q + 32'd1;
      if (redirect_valid && redirect_ready) perf_tk_q <= perf_tk_q + 32'd1;
    end
  end

  assign perf_branches = perf_br_q;
  assign perf_taken    = perf_tk_q;
`else
  assign perf_branches = 32'd0;
  assign perf_taken    = 32'd0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: directed cases plus randomized requests
// against a behavioural model of branch/jump resolution.
module tb_branch_ctrl;
  import branch_pkg::*;

  localparam int XLEN = 32;
  localparam int FC   = 2;
  localparam int W    = 34;
`ifdef BRANCH_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  localparam logic [1:0] K_DONE = 2'd0;
  localparam logic [1:0] K_RED  = 2'd1;
  localparam logic [1:0] K_ILL  = 2'd2;
  localparam logic [1:0] K_MIS  = 2'd3;

  logic            clk, rst;
  logic            req_valid, req_ready;
  logic [1:0]      req_type;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_rs1, req_rs2, req_pc, req_imm;
  logic            redirect_valid, redirect_ready;
  logic [XLEN-1:0] redirect_pc;
  logic            flush, done, illegal, misalign;
  logic [31:0]     perf_branches, perf_taken;
  branch_state_t   dbg_state;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int unsigned m_branches = 0;
  int unsigned m_taken    = 0;

  branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_type       (req_type),
    .req_funct3     (req_funct3),
    .req_rs1        (req_rs1),
    .req_rs2        (req_rs2),
    .req_pc         (req_pc),
    .req_imm        (req_imm),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .flush          (flush),
    .done           (done),
    .illegal        (illegal),
    .misalign       (misalign),
    .perf_branches  (perf_branches),
    .perf_taken     (perf_taken),
    .dbg_state      (dbg_state)
  );

  // Clock and global time bound
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one event per request, {kind, redirect target}
  function automatic logic [W-1:0] model(input logic [1:0] t, input logic [2:0] f3,
                                         input logic [31:0] rs1, input logic [31:0] rs2,
                                         input logic [31:0] pc, input logic [31:0] imm);
    bit taken;
    logic [31:0] tgt;
    taken = 1'b1;
    if (t == 2'b11) return {K_ILL, 32'h0};
    if (t == 2'b00) begin
      case (f3)
        3'b000: taken = (rs1 == rs2);
        3'b001: taken = (rs1 != rs2);
        3'b100: taken = ($signed(rs1) <  $signed(rs2));
        3'b101: taken = ($signed(rs1) >= $signed(rs2));
        3'b110: taken = (rs1 <  rs2);
        3'b111: taken = (rs1 >= rs2);
        default: return {K_ILL, 32'h0};
      endcase
    end
    tgt = (t == 2'b10) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    if (!taken) return {K_DONE, 32'h0};
    if (tgt[1:0] != 2'b00) return {K_MIS, 32'h0};
    return {K_RED, tgt};
  endfunction

  // Monitor: pops the expected queue on every observed output event
  logic [W-1:0] got, e_mon;
  logic         got_valid, prev_stall;
  logic [31:0]  prev_pc;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("rdr_hold_valid", redirect_valid, 1'b1);
        chk("rdr_hold_pc", redirect_pc, prev_pc);
      end
      got_valid = 1'b1;
      got       = '0;
      if (illegal)                               got = {K_ILL, 32'h0};
      else if (misalign)                         got = {K_MIS, 32'h0};
      else if (redirect_valid && redirect_ready) got = {K_RED, redirect_pc};
      else if (done)                             got = {K_DONE, 32'h0};
      else                                       got_valid = 1'b0;
      if (got_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got %0h expected none", got);
        end else begin
          e_mon = exp_q.pop_front();
          chk("event", got, e_mon);
        end
      end
      prev_stall = redirect_valid && !redirect_ready;
      prev_pc    = redirect_pc;
    end
  end

  task automatic check_perf();
    chk("perf_branches", perf_branches, PERF_EN ? 64'(m_branches) : 64'd0);
    chk("perf_taken", perf_taken, PERF_EN ? 64'(m_taken) : 64'd0);
  endtask

  // Driver: one request end to end, with cycle-exact protocol checks
  task automatic do_req(input logic [1:0] t, input logic [2:0] f3,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input int stall, input bit rst_in_flush);
    logic [W-1:0] e;
    int n;
    e = model(t, f3, rs1, rs2, pc, imm);
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: got 0 expected 1");
      return;
    end
    req_valid = 1'b1; req_type = t; req_funct3 = f3;
    req_rs1 = rs1; req_rs2 = rs2; req_pc = pc; req_imm = imm;
    redirect_ready = (stall == 0);
    exp_q.push_back(e);
    if (e[33:32] == K_RED) exp_q.push_back({K_DONE, 32'h0});
    @(posedge clk); #1;
    // Garbage on the request bus must not be sampled while busy
    req_valid = 1'b0; req_type = 2'($urandom()); req_funct3 = 3'($urandom());
    req_rs1 = $urandom(); req_rs2 = $urandom(); req_pc = $urandom(); req_imm = $urandom();
    chk("ready_n1", req_ready, 1'b0);
    chk("done_n1", done, e[33:32] == K_DONE);
    chk("illegal_n1", illegal, e[33:32] == K_ILL);
    chk("misalign_n1", misalign, e[33:32] == K_MIS);
    chk("rdr_valid_n1", redirect_valid, 1'b0);
    if (e[33:32] != K_RED) begin
      m_branches++;
      @(posedge clk); #1;
      chk("ready_n2", req_ready, 1'b1);
      chk("rdr_valid_n2", redirect_valid, 1'b0);
      check_perf();
      return;
    end
    @(posedge clk); #1;
    chk("rdr_valid_n2", redirect_valid, 1'b1);
    chk("rdr_pc_n2", redirect_pc, e[31:0]);
    for (int i = 0; i < stall; i++) begin
      chk("ready_stall", req_ready, 1'b0);
      chk("flush_stall", flush, 1'b0);
      @(posedge clk); #1;
      chk("rdr_valid_stall", redirect_valid, 1'b1);
    end
    redirect_ready = 1'b1;
    m_taken++;
    @(posedge clk); #1;
    if (rst_in_flush) begin
      chk("flush_first", flush, 1'b1);
      rst = 1'b1;
      void'(exp_q.pop_back());
      m_branches = 0;
      m_taken    = 0;
      @(posedge clk); #1;
      chk("rst_flush", flush, 1'b0);
      chk("rst_ready", req_ready, 1'b1);
      chk("rst_rdr_valid", redirect_valid, 1'b0);
      chk("rst_perf_branches", perf_branches, 32'd0);
      chk("rst_perf_taken", perf_taken, 32'd0);
      rst = 1'b0;
      return;
    end
    for (int i = 0; i < FC; i++) begin
      chk("flush_on", flush, 1'b1);
      chk("done_flush", done, i == FC - 1);
      chk("rdr_valid_flush", redirect_valid, 1'b0);
      @(posedge clk); #1;
    end
    m_branches++;
    chk("flush_off", flush, 1'b0);
    chk("ready_after", req_ready, 1'b1);
    check_perf();
  endtask

  initial begin
    logic [1:0]  t;
    logic [31:0] a, b;
    int sel;
    rst = 1'b1; req_valid = 1'b0; req_type = '0; req_funct3 = '0;
    req_rs1 = '0; req_rs2 = '0; req_pc = '0; req_imm = '0; redirect_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", req_ready, 1'b1);
    chk("reset_rdr_valid", redirect_valid, 1'b0);
    chk("reset_rdr_pc", redirect_pc, 32'h0);
    chk("reset_flush", flush, 1'b0);
    chk("reset_pulses", {done, illegal, misalign}, 3'b000);
    chk("reset_perf", {perf_branches, perf_taken}, 64'h0);
    rst = 1'b0;

    do_req(2'b00, F3_BEQ,  32'h5,        32'h5, 32'h100, 32'h20, 0, 0);
    do_req(2'b00, F3_BLT,  32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 0, 0);
    do_req(2'b00, F3_BLTU, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 0, 0);
    do_req(2'b10, 3'b000,  32'h203, 32'h0, 32'h300, 32'h0, 0, 0);
    do_req(2'b10, 3'b000,  32'h201, 32'h0, 32'h300, 32'h0, 0, 0);
    do_req(2'b00, F3_BNE,  32'h1, 32'h2, 32'h400, 32'h10, 3, 0);
    do_req(2'b00, F3_BEQ,  32'h7, 32'h7, 32'h500, 32'h8, 0, 1);
    do_req(2'b00, F3_BGE,  32'h8000_0000, 32'h7FFF_FFFF, 32'h600, 32'h4, 0, 0);
    do_req(2'b00, F3_BGEU, 32'h8000_0000, 32'h7FFF_FFFF, 32'h600, 32'h4, 1, 0);
    do_req(2'b00, 3'b010,  32'h1, 32'h1, 32'h700, 32'h8, 0, 0);
    do_req(2'b11, 3'b000,  32'h1, 32'h1, 32'h700, 32'h8, 0, 0);
    do_req(2'b01, 3'b000,  32'h0, 32'h0, 32'h10, 32'hFFFF_FFF0, 0, 0);
    do_req(2'b01, 3'b000,  32'h0, 32'h0, 32'hFFFF_FFFC, 32'h8, 2, 0);
    do_req(2'b00, F3_BEQ,  32'h3, 32'h3, 32'h800, 32'h6, 0, 0);

    for (int k = 0; k < 200; k++) begin
      sel = $urandom_range(0, 9);
      t   = (sel <= 5) ? 2'b00 : (sel == 6) ? 2'b01 : (sel <= 8) ? 2'b10 : 2'b11;
      a   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : $urandom();
      b   = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : $urandom());
      do_req(t, (t == 2'b00 || t == 2'b11) ? 3'($urandom()) : 3'b000, a, b,
             $urandom() & 32'hFFFF_FFFC,
             ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC),
             $urandom_range(0, 3), 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch resolution and redirect controller for the RISC-V core. It accepts one branch or jump per handshake from the execute stage and sequences the branch comparator. It computes the target, delivers a redirect to fetch over a valid/ready handshake, and then drives a fixed-length pipeline flush. While busy it back-pressures the execute stage, so it is the single owner of the comparator and of the PC-redirect path.

## Interface
- `XLEN`, 32: operand, PC and immediate width.
- `FLUSH_CYCLES`, 2: cycles `flush` stays high after a redirect is accepted; legal range 1..15.
- `clk` in 1: core clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: execute stage presents a branch/jump.
- `req_ready` out 1: controller can accept a request.
- `req_type` in 2: 00 conditional branch, 01 JAL, 10 JALR, 11 reserved (treated as not taken, illegal).
- `req_funct3` in 3: branch condition (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
- `req_rs1` in XLEN: rs1 operand.
- `req_rs2` in XLEN: rs2 operand.
- `req_pc` in XLEN: PC of the branch.
- `req_imm` in XLEN: sign-extended immediate.
- `redirect_valid` out 1: new fetch PC is offered.
- `redirect_pc` out XLEN: target PC.
- `redirect_ready` in 1: fetch accepts the redirect.
- `flush` out 1: kill younger instructions in IF/ID.
- `done` out 1: one-cycle pulse when a request retires without error.
- `illegal` out 1: one-cycle pulse for a reserved `req_type` or for funct3 010/011.
- `misalign` out 1: one-cycle pulse when a taken target has bits [1:0] != 0.
- `perf_branches` out 32: retired branch/jump count.
- `perf_taken` out 32: taken count.

## Operation
- States: IDLE, RESOLVE, REDIRECT, FLUSH.
- IDLE
  - `req_ready`=1.
  - On `req_valid`, register all request fields and go to RESOLVE.
- RESOLVE
  - Evaluate the condition on the registered operands. BLT/BGE compare signed; BLTU/BGEU compare unsigned.
  - JAL and JALR are always taken.
  - Target: `pc+imm` for branches and JAL; `(rs1+imm) & ~1` for JALR. Arithmetic is modulo 2^XLEN and wraps silently.
  - Illegal encoding: pulse `illegal`, go to IDLE.
  - Not taken: pulse `done`, go to IDLE.
  - Taken with target[1:0] != 0: pulse `misalign`, go to IDLE, no redirect.
  - Taken and aligned: go to REDIRECT.
- REDIRECT
  - `redirect_valid`=1 and `redirect_pc` are held stable until `redirect_ready`.
  - On acceptance, go to FLUSH and load the counter with FLUSH_CYCLES.
- FLUSH
  - `flush`=1 and the counter decrements each cycle.
  - On the cycle the counter reads 1, pulse `done` and go to IDLE.
- `req_ready`=0 in every state except IDLE. Requests presented while busy are not sampled.
- `rst` in any state, including mid-REDIRECT or mid-FLUSH, forces IDLE next cycle. Any pending redirect is dropped.
- Reset values: `req_ready`=1; `redirect_valid`, `flush`, `done`, `illegal`, `misalign`=0; `redirect_pc`=0; perf counters=0.

## Timing
- Request accepted at edge N, RESOLVE during cycle N+1.
- Not-taken: `done` in cycle N+1; `req_ready` high again in cycle N+2.
- Taken: `redirect_valid` is first high in cycle N+2.
  - If `redirect_ready` is already high in that cycle, it is accepted there and `flush` is high for cycles N+3..N+2+FLUSH_CYCLES.
  - `done` pulses in the last flush cycle; `req_ready` returns the following cycle.
- `redirect_pc` must not change while `redirect_valid`=1 and `redirect_ready`=0.
- Outputs are registered; there is no combinational path from `req_*` to `redirect_*`.

## Configuration
- `BRANCH_PERF_EN` defined:
  - `perf_branches` increments on each `done`, `illegal` or `misalign` event.
  - `perf_taken` increments on each redirect acceptance.
  - Both wrap from 2^32-1 to 0 and are cleared by `rst`.
- `BRANCH_PERF_EN` undefined: both ports remain and are tied to 0; no counter flops are generated.

## Structure
- Shared package `branch_pkg` holds:
  - the funct3 localparams (`F3_BEQ`..`F3_BGEU`);
  - the `req_type` encodings;
  - the FSM state typedef `branch_state_t`.
- One sub-module, `branch_cond_unit`: combinational; inputs rs1, rs2, funct3; outputs taken and illegal. It covers all six conditions, replacing the single-equality comparator.
- The FSM, target adder, flush counter and perf counters live in `branch_ctrl`.

## Test plan
- BEQ, rs1=rs2=0x5, pc=0x100, imm=0x20, `redirect_ready`=1
  -> `redirect_pc`=0x120 at N+2; `flush` high 2 cycles; `done` at N+4.
- BLT, rs1=0xFFFFFFFF, rs2=1 (signed -1<1); then BLTU with the same operands
  -> first is taken; second is not taken, with `done` at N+1 and no redirect.
- JALR, rs1=0x203, imm=0
  -> target 0x202 (bit0 cleared), `misalign`=1, no redirect.
  - Same with rs1=0x201 -> `redirect_pc`=0x200.
- Taken branch with `redirect_ready` held low 3 cycles
  -> `redirect_valid` and `redirect_pc` stable for 4 cycles, `req_ready`=0 throughout, flush starts after acceptance.
- `rst` asserted during the 1st FLUSH cycle
  -> next cycle: `flush`=0, `req_ready`=1, perf counters=0; a new request is accepted normally.
- funct3=010 and `req_type`=11
  -> `illegal` pulses at N+1, no redirect; with `BRANCH_PERF_EN` defined, `perf_branches` increments and `perf_taken` does not.
